// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus constants, FSM state codes and mode encodings for the master port
package bus_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } mode_e;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ      = 3'd1;
    localparam logic [2:0] ST_ADDR     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_WDATA    = 3'd4;
    localparam logic [2:0] ST_RWAIT    = 3'd5;
    localparam logic [2:0] ST_RDATA    = 3'd6;
    localparam logic [2:0] ST_SPLIT    = 3'd7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/shift_reg.sv
// rtl/shift_reg.sv - parameterised shift register, parallel load, LSB-first shift right
module shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout
);

    // serial input enters at the MSB so an LSB-first stream ends up in natural order
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/master_port.sv
// rtl/master_port.sv - parallel-to-serial bus master front end; MASTER_PORT_TIMEOUT_EN enables the ack timeout
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dvalid,
    output logic                  dready,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  ddone,
    output logic                  derr,
    output logic                  breq,
    input  logic                  bgrant,
    output logic                  wdata,
    output logic                  mode,
    output logic                  mvalid,
    input  logic                  rdata,
    input  logic                  svalid,
    input  logic                  ack,
    input  logic                  split
);

    localparam int TX_W  = max_int(ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_W = $clog2(TX_W);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    // bit 0 is captured in RWAIT, so RDATA counts the remaining DATA_WIDTH-1 bits
    localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(DATA_WIDTH - 2);

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [CNT_W-1:0]      cnt;
    logic                  cnt_inc;
    logic                  mode_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  tx_load;
    logic [TX_W-1:0]       tx_load_val;
    logic                  tx_shift;
    logic                  tx_sout;
    logic [TX_W-1:0]       tx_unused_q;
    logic                  rx_shift;
    logic [DATA_WIDTH-2:0] rx_q;
    logic                  rx_unused_sout;
    logic                  done_set;
    logic                  rd_done;
    logic                  err_set;
    logic                  err_q;
    logic                  timeout_hit;

    shift_reg #(.WIDTH(TX_W)) u_tx (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tx_load),
        .load_val (tx_load_val),
        .shift    (tx_shift),
        .sin      (1'b0),
        .q        (tx_unused_q),
        .sout     (tx_sout)
    );

    shift_reg #(.WIDTH(DATA_WIDTH - 1)) u_rx (
        .clk      (clk),
        .rstn     (rstn),
        .load     (1'b0),
        .load_val ('0),
        .shift    (rx_shift),
        .sin      (rdata),
        .q        (rx_q),
        .sout     (rx_unused_sout)
    );

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (!rstn || state != ST_WAIT_ACK) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (to_cnt == TO_W'(ACK_TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (ACK_TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        cnt_inc     = 1'b0;
        tx_load     = 1'b0;
        tx_load_val = TX_W'(daddr);
        tx_shift    = 1'b0;
        rx_shift    = 1'b0;
        done_set    = 1'b0;
        rd_done     = 1'b0;
        err_set     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dvalid) begin
                    tx_load    = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bgrant) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (bgrant) begin
                    tx_shift = 1'b1;
                    cnt_inc  = 1'b1;
                    if (cnt == ADDR_LAST) state_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack) begin
                    if (mode_q == MODE_WRITE) begin
                        tx_load     = 1'b1;
                        tx_load_val = TX_W'(wdata_q);
                        state_next  = ST_WDATA;
                    end else begin
                        state_next = ST_RWAIT;
                    end
                end else if (timeout_hit) begin
                    err_set    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (bgrant) begin
                    tx_shift = 1'b1;
                    cnt_inc  = 1'b1;
                    if (cnt == DATA_LAST) begin
                        done_set   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_RWAIT: begin
                if (split) begin
                    state_next = ST_SPLIT;
                end else if (svalid) begin
                    rx_shift   = 1'b1;
                    state_next = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (svalid) begin
                    rx_shift = 1'b1;
                    cnt_inc  = 1'b1;
                    if (cnt == RX_LAST) begin
                        done_set   = 1'b1;
                        rd_done    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_SPLIT: begin
                if (!split && bgrant) state_next = ST_RWAIT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            mode_q  <= 1'b0;
            wdata_q <= '0;
            drdata  <= '0;
            ddone   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            ddone <= done_set;
            err_q <= err_set;
            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (state == ST_IDLE && dvalid) begin
                mode_q  <= dmode;
                wdata_q <= dwdata;
            end
            if (rd_done) drdata <= {rdata, rx_q};
        end
    end

    assign derr   = err_q;
    assign dready = (state == ST_IDLE);
    assign breq   = (state != ST_IDLE);
    assign mvalid = (state == ST_ADDR || state == ST_WDATA) && bgrant;
    assign wdata  = mvalid && tx_sout;
    assign mode   = (state != ST_IDLE) && mode_q;

endmodule

// File: tb/tb_master_port.sv
// tb/tb_master_port.sv - scoreboard bench for master_port: serial bit stream and completion checks
`timescale 1ns/1ps
module tb_master_port;
    import bus_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          dvalid = 1'b0;
    logic          dready;
    logic          dmode = 1'b0;
    logic [AW-1:0] daddr = '0;
    logic [DW-1:0] dwdata = '0;
    logic [DW-1:0] drdata;
    logic          ddone;
    logic          derr;
    logic          breq;
    logic          bgrant;
    logic          wdata;
    logic          mode;
    logic          mvalid;
    logic          rdata = 1'b0;
    logic          svalid = 1'b0;
    logic          ack;
    logic          split = 1'b0;

    logic grant_en = 1'b1;
    logic ack_en   = 1'b1;
    int   nbits    = 0;
    int   cyc      = 0;

    typedef struct {
        bit          err;
        bit          chk_data;
        logic [7:0]  data;
        int          cyc;
    } cpl_t;

    cpl_t cpl_q[$];
    bit   bit_q[$];
    logic exp_mode = 1'b0;
    int   nvec = 0;
    int   nmis = 0;
    cpl_t mon_c;
    bit   mon_b;

    master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACK_TIMEOUT(15)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .dvalid (dvalid),
        .dready (dready),
        .dmode  (dmode),
        .daddr  (daddr),
        .dwdata (dwdata),
        .drdata (drdata),
        .ddone  (ddone),
        .derr   (derr),
        .breq   (breq),
        .bgrant (bgrant),
        .wdata  (wdata),
        .mode   (mode),
        .mvalid (mvalid),
        .rdata  (rdata),
        .svalid (svalid),
        .ack    (ack),
        .split  (split)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // arbiter grants on request; decoder acks the cycle after the last address bit
    assign bgrant = breq & grant_en;
    assign ack    = ack_en & (nbits == AW) & !mvalid & breq;

    always @(posedge clk) begin
        if (!rstn || (dvalid && dready)) nbits <= 0;
        else if (mvalid) nbits <= nbits + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (ddone || derr) begin
                check("ddone_derr_exclusive", {31'd0, ddone & derr}, 32'd0);
                check("cpl_pending", {31'd0, cpl_q.size() > 0}, 32'd1);
                if (cpl_q.size() > 0) begin
                    mon_c = cpl_q.pop_front();
                    check("cpl_kind", {31'd0, derr}, {31'd0, mon_c.err});
                    if (mon_c.cyc >= 0) check("cpl_cycle", cyc, mon_c.cyc);
                    if (mon_c.chk_data) check("drdata", {24'd0, drdata}, {24'd0, mon_c.data});
                    if (mon_c.err) begin
                        check("err_breq", {31'd0, breq}, 32'd0);
                        check("err_dready", {31'd0, dready}, 32'd1);
                    end
                end
            end
            if (mvalid) begin
                check("bit_pending", {31'd0, bit_q.size() > 0}, 32'd1);
                if (bit_q.size() > 0) begin
                    mon_b = bit_q.pop_front();
                    check("wdata_bit", {31'd0, wdata}, {31'd0, mon_b});
                    check("mode_held", {31'd0, mode}, {31'd0, exp_mode});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d, output int h);
        check("dready_idle", {31'd0, dready}, 32'd1);
        dvalid   = 1'b1;
        dmode    = m;
        daddr    = a;
        dwdata   = d;
        exp_mode = m;
        for (int i = 0; i < AW; i++) bit_q.push_back(a[i]);
        if (m) for (int i = 0; i < DW; i++) bit_q.push_back(d[i]);
        h = cyc;
        tick();
        dvalid = 1'b0;
    endtask

    task automatic wait_nbits(input int n);
        for (int i = 0; i < 200 && nbits != n; i++) tick();
        check("reach_nbits", nbits, n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && !dready; i++) tick();
        check("return_idle", {31'd0, dready}, 32'd1);
    endtask

    task automatic send_read(input logic [DW-1:0] d, input int gap_after);
        cpl_t c;
        for (int i = 0; i < DW; i++) begin
            svalid = 1'b1;
            rdata  = d[i];
            if (i == DW - 1) begin
                c.err = 1'b0; c.chk_data = 1'b1; c.data = d; c.cyc = cyc + 1;
                cpl_q.push_back(c);
            end
            tick();
            if (i == gap_after) begin
                svalid = 1'b0;
                rdata  = 1'b1;
                tick();
            end
        end
        svalid = 1'b0;
        rdata  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dready"}, {31'd0, dready}, 32'd1);
        check({tag, "_breq"},   {31'd0, breq},   32'd0);
        check({tag, "_mvalid"}, {31'd0, mvalid}, 32'd0);
        check({tag, "_wdata"},  {31'd0, wdata},  32'd0);
        check({tag, "_mode"},   {31'd0, mode},   32'd0);
        check({tag, "_ddone"},  {31'd0, ddone},  32'd0);
        check({tag, "_derr"},   {31'd0, derr},   32'd0);
        check({tag, "_drdata"}, {24'd0, drdata}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   h;
        cpl_t c;

        rstn = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        // write 0x1234 <- 0xA5, immediate grant and ack
        issue(1'b1, 16'h1234, 8'hA5, h);
        c.err = 1'b0; c.chk_data = 1'b0; c.data = '0; c.cyc = h + 27;
        cpl_q.push_back(c);
        for (int i = 0; i < 3; i++) begin
            dvalid = 1'b1; daddr = 16'hFFFF; dmode = 1'b0;
            check("busy_dready", {31'd0, dready}, 32'd0);
            tick();
        end
        dvalid = 1'b0;
        wait_idle();
        check("drdata_after_write", {24'd0, drdata}, 32'd0);
        tick();

        // read 0x2010 returning 0x3C with a gap after bit 1
        issue(1'b0, 16'h2010, 8'h00, h);
        wait_nbits(AW);
        tick();
        send_read(8'h3C, 1);
        wait_idle();
        tick();

        // read to a split slave: 20 cycles of split with grant withdrawn
        issue(1'b0, 16'h4000, 8'h00, h);
        wait_nbits(AW);
        tick();
        split = 1'b1; svalid = 1'b1; rdata = 1'b1; grant_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("split_breq", {31'd0, breq}, 32'd1);
        end
        split = 1'b0; svalid = 1'b0; rdata = 1'b0; grant_en = 1'b1;
        tick();
        send_read(8'h96, -1);
        wait_idle();
        check("drdata_stable", {24'd0, drdata}, 32'h96);
        tick();

        // grant withdrawn for 3 cycles after 5 address bits
        issue(1'b1, 16'hC3A5, 8'h5A, h);
        c.err = 1'b0; c.chk_data = 1'b0; c.data = '0; c.cyc = h + 30;
        cpl_q.push_back(c);
        wait_nbits(5);
        for (int i = 0; i < 3; i++) begin
            grant_en = 1'b0;
            #1;
            check("nogrant_mvalid", {31'd0, mvalid}, 32'd0);
            check("nogrant_breq", {31'd0, breq}, 32'd1);
            tick();
        end
        grant_en = 1'b1;
        wait_idle();
        check("drdata_after_write2", {24'd0, drdata}, 32'h96);
        tick();

        // reset asserted while WDATA bit 3 is on the wire
        issue(1'b1, 16'h5555, 8'hFF, h);
        wait_nbits(AW + 3);
        check("wdata_bit3_live", {31'd0, mvalid}, 32'd1);
        rstn = 1'b0;
        tick();
        check_reset_outputs("midreset");
        bit_q.delete();
        rstn = 1'b1;
        repeat (5) tick();

        // no ack from the decoder
        ack_en = 1'b0;
        issue(1'b0, 16'h8001, 8'h00, h);
`ifdef MASTER_PORT_TIMEOUT_EN
        c.err = 1'b1; c.chk_data = 1'b0; c.data = '0; c.cyc = h + 33;
        cpl_q.push_back(c);
        wait_idle();
        check("timeout_idle_cycle", cyc, h + 33);
        check("timeout_breq", {31'd0, breq}, 32'd0);
`else
        repeat (40) tick();
        check("noack_breq_held", {31'd0, breq}, 32'd1);
        check("noack_dready", {31'd0, dready}, 32'd0);
        rstn = 1'b0;
        tick();
        check_reset_outputs("noack_reset");
        rstn = 1'b1;
`endif
        ack_en = 1'b1;
        repeat (5) tick();

        check("cpl_queue_empty", cpl_q.size(), 32'd0);
        check("bit_queue_empty", bit_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/master_port.md
# master_port

Per-master front end that converts one parallel read or write request into the serial master-side protocol of the 2-master/3-slave system bus. It owns bus request, address serialisation, write-data serialisation and read-data deserialisation, including split handling. It sits between a master core (user side) and one master port of the bus interconnect (m1_* or m2_*).

## Interface
- ADDR_WIDTH, 16, full bus address width (device bits in MSBs)
- DATA_WIDTH, 8, data word width
- ACK_TIMEOUT, 15, max cycles waited for ack after address

- clk  in  1  clock, rising edge
- rstn  in  1  synchronous active-low reset
- dvalid  in  1  user request valid
- dready  out  1  high in IDLE only; request accepted on dvalid&&dready
- dmode  in  1  0 read, 1 write
- daddr  in  ADDR_WIDTH  request address
- dwdata  in  DATA_WIDTH  write data
- drdata  out  DATA_WIDTH  read data, valid with ddone on reads
- ddone  out  1  one-cycle completion pulse
- derr  out  1  one-cycle error pulse (timeout), exclusive with ddone
- breq  out  1  to arbiter
- bgrant  in  1  from arbiter
- wdata  out  1  serial address/write data
- mode  out  1  held for whole transaction
- mvalid  out  1  wdata bit valid
- rdata  in  1  serial read data
- svalid  in  1  rdata bit valid
- ack  in  1  address accepted by decoder
- split  in  1  slave has split this master

## Operation
- States: IDLE, REQ, ADDR, WAIT_ACK, WDATA, RWAIT, RDATA, SPLIT.
- IDLE: dready=1; on handshake latch daddr/dwdata/dmode -> REQ.
- REQ: breq=1; on bgrant -> ADDR.
- ADDR: ADDR_WIDTH cycles, wdata=addr bit, LSB first, mvalid=1; after last bit -> WAIT_ACK.
- WAIT_ACK: mvalid=0; ack=1 -> WDATA (write) or RWAIT (read).
- WDATA: DATA_WIDTH cycles, LSB first, mvalid=1; after last bit ddone, breq=0 -> IDLE.
- RWAIT: split=1 -> SPLIT; svalid=1 -> capture bit 0, -> RDATA.
- RDATA: shift in one bit per svalid cycle (gaps allowed); after DATA_WIDTH bits ddone, breq=0 -> IDLE.
- SPLIT: breq held 1; ignore svalid; when split=0 and bgrant=1 -> RWAIT.
- bgrant drop in ADDR/WDATA: freeze bit counter, mvalid=0, resume on regrant.
- Bit counter width clog2(max(ADDR_WIDTH,DATA_WIDTH)); counter clears on every state entry.
- breq is high from REQ until the cycle after last bit/ack completion; never high in IDLE.

## Timing
- Reset: all outputs 0 except dready=1; state IDLE; drdata=0.
- Reset mid-transaction: aborts immediately, breq/mvalid drop next edge, no ddone/derr.
- Write latency, grant in first REQ cycle, ack in first WAIT_ACK cycle: handshake@0, REQ@1, ADDR@2..17, WAIT_ACK@18, WDATA@19..26, ddone@27.
- Read: ddone cycle after last svalid bit; drdata stable until next read completes.
- dvalid while busy ignored (dready=0).
- ack and split same cycle in WAIT_ACK: ack wins; split then sampled in RWAIT.

## Configuration
- MASTER_PORT_TIMEOUT_EN defined: WAIT_ACK counts cycles; ACK_TIMEOUT cycles without ack -> derr pulse, breq=0, IDLE.
- Undefined: WAIT_ACK waits indefinitely; derr tied 0.

## Structure
- bus_pkg: state enum, default ADDR_WIDTH/DATA_WIDTH, mode encodings (MODE_READ=0, MODE_WRITE=1).
- One natural sub-module: shift_reg (parameterised PISO/SIPO, load/shift/enable), used for address/write and read paths.

## Test plan
- Write 0x1234 <- 0xA5, immediate grant/ack -> wdata bits 0x1234 LSB first then 0xA5, ddone at cycle 27.
- Read 0x2010, slave returns 0x3C with one-cycle svalid gap -> drdata=0x3C, ddone after 8th bit.
- Read to split slave: split high 20 cycles after ack, then regrant -> breq held throughout, drdata correct, one ddone.
- Grant withdrawn after 5 address bits for 3 cycles -> mvalid=0 for 3 cycles, remaining 11 bits sent, address intact.
- MASTER_PORT_TIMEOUT_EN, no ack -> derr exactly 15 cycles after WAIT_ACK entry, breq=0, dready=1 next cycle.
- rstn low during WDATA bit 3 -> next edge all outputs reset values, no ddone.
